ctrl_pipe_cond: RTL

- Parametrised control-signal pipeline for the pipelined processor.
- Carries decoded control from the Decode stage through Execute, a configurable number of Memory stages, and Writeback.
- Evaluates ARM condition codes against an internal NZCV flag register and gates write/branch controls.
- Adds over the previous generation: an Execute stall, per-stage valid bits, and a pass-through sideband of generic width.

---
 rtl/ctrl_pipe_pkg.sv | 48 ++++
 rtl/cond_check.sv | 39 +++
 rtl/ctrl_pipe_flops.sv | 33 +++
 rtl/ctrl_pipe_cond.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/ctrl_pipe_pkg.sv
// Shared definitions for the control pipeline: ARM condition codes, NZCV bit
// positions and the packed bundles carried by the D->E and Memory-stage registers.
package ctrl_pipe_pkg;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef struct packed {
        logic       valid;
        logic [3:0] cond;
        logic       pcSrc;
        logic       regWrite;
        logic       memtoReg;
        logic       memWrite;
        logic       branch;
        logic       noWrite;
        logic [1:0] flagWrite;
    } DeBundle;

    typedef struct packed {
        logic valid;
        logic pcSrc;
        logic regWrite;
        logic memtoReg;
    } MBundle;

    localparam int DE_CTRL_W  = $bits(DeBundle);
    localparam int M_BUNDLE_W = $bits(MBundle);

endpackage

// File: rtl/cond_check.sv
// Combinational ARM condition evaluation of the Execute-stage condition field
// against the current NZCV flag register.
module cond_check
    import ctrl_pipe_pkg::*;
(
    input  logic [3:0] CondE,
    input  logic [3:0] Flags,
    output logic       CondEx
);
    logic n, z, c, v;

    assign n = Flags[FLAG_N];
    assign z = Flags[FLAG_Z];
    assign c = Flags[FLAG_C];
    assign v = Flags[FLAG_V];

    // NOTE: the default before the case covers AL/1111 and keeps this block latch-free.
    always_comb begin
        CondEx = 1'b1;
        case (CondE)
            COND_EQ: CondEx = z;
            COND_NE: CondEx = ~z;
            COND_CS: CondEx = c;
            COND_CC: CondEx = ~c;
            COND_MI: CondEx = n;
            COND_PL: CondEx = ~n;
            COND_VS: CondEx = v;
            COND_VC: CondEx = ~v;
            COND_HI: CondEx = c & ~z;
            COND_LS: CondEx = ~c | z;
            COND_GE: CondEx = (n == v);
            COND_LT: CondEx = (n != v);
            COND_GT: CondEx = ~z & (n == v);
            COND_LE: CondEx = z | (n != v);
            COND_AL: CondEx = 1'b1;
            default: CondEx = 1'b1;
        endcase
    end
endmodule

// File: rtl/ctrl_pipe_flops.sv
// Register primitives for the control pipeline: plain reset flop (flopr) and
// enable flop with synchronous clear taking priority over the enable (flopenrc).
module flopr #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) q <= '0;
        else        q <= d;
    end
endmodule

module flopenrc #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clear,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)     q <= '0;
        else if (clear) q <= '0;
        else if (en)    q <= d;
    end
endmodule

// File: rtl/ctrl_pipe_cond.sv
// Control pipeline D->E->M[1..MEM_LAT]->W with condition-gated writes and NZCV flags.
// Define CTRL_PIPE_PERF_EN to add RetiredCnt/CondFailCnt performance counters.
module ctrl_pipe_cond
    import ctrl_pipe_pkg::*;
#(
    parameter int SIDE_W  = 5,
    parameter int MEM_LAT = 1,
    parameter int CNT_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ValidD,
    input  logic [3:0]        CondD,
    input  logic              PCSrcD,
    input  logic              RegWriteD,
    input  logic              MemtoRegD,
    input  logic              MemWriteD,
    input  logic              BranchD,
    input  logic              NoWriteD,
    input  logic [1:0]        FlagWriteD,
    input  logic [SIDE_W-1:0] SideD,
    input  logic [3:0]        ALUFlags,
    input  logic              StallE,
    input  logic              FlushE,
    output logic [SIDE_W-1:0] SideE,
    output logic              MemtoRegE,
    output logic              CondExE,
    output logic              BranchTakenE,
    output logic              FlagCarryE,
    output logic              PCSrcM,
    output logic              RegWriteM,
    output logic              MemWriteM,
    output logic              PCSrcW,
    output logic              RegWriteW,
    output logic              MemtoRegW,
    output logic              BusyMW
`ifdef CTRL_PIPE_PERF_EN
    ,
    output logic [CNT_W-1:0]  RetiredCnt,
    output logic [CNT_W-1:0]  CondFailCnt
`endif
);
    if (MEM_LAT < 1 || MEM_LAT > 4 || CNT_W < 1) begin : gBadParams
        $error("ctrl_pipe_cond: MEM_LAT must be 1..4 and CNT_W positive");
    end

    DeBundle                     bundleD;
    DeBundle                     bundleE;
    logic [DE_CTRL_W+SIDE_W-1:0] regEQ;
    logic [1:0]                  flagsNZ;
    logic [1:0]                  flagsCV;
    logic [3:0]                  flags;
    logic                        condOk;
    logic                        flagEn;
    MBundle                      mIn;
    logic                        memWriteIn;
    MBundle                      mQ [MEM_LAT];
    MBundle                      wStage;

    always_comb begin
        bundleD = '0;
        if (ValidD) begin
            bundleD.valid     = 1'b1;
            bundleD.cond      = CondD;
            bundleD.pcSrc     = PCSrcD;
            bundleD.regWrite  = RegWriteD;
            bundleD.memtoReg  = MemtoRegD;
            bundleD.memWrite  = MemWriteD;
            bundleD.branch    = BranchD;
            bundleD.noWrite   = NoWriteD;
            bundleD.flagWrite = FlagWriteD;
        end
    end

    // Flush clears regardless of stall, so a flushed-and-stalled E still becomes a bubble.
    flopenrc #(.WIDTH(DE_CTRL_W + SIDE_W)) regE (
        .clk, .reset, .en(~StallE), .clear(FlushE),
        .d({bundleD, SideD}), .q(regEQ)
    );

    assign bundleE = regEQ[DE_CTRL_W+SIDE_W-1:SIDE_W];
    assign SideE   = regEQ[SIDE_W-1:0];

    assign flags = {flagsNZ, flagsCV};

    cond_check uCond (.CondE(bundleE.cond), .Flags(flags), .CondEx(condOk));

    assign CondExE      = condOk & bundleE.valid;
    assign MemtoRegE    = bundleE.memtoReg;
    assign BranchTakenE = bundleE.branch & CondExE & ~StallE;
    assign FlagCarryE   = flags[FLAG_C];
    assign flagEn       = CondExE & ~StallE;

    // No bypass: the next instruction in E sees these flags one cycle later.
    flopenrc #(.WIDTH(2)) regNZ (
        .clk, .reset, .en(flagEn & bundleE.flagWrite[1]), .clear(1'b0),
        .d(ALUFlags[3:2]), .q(flagsNZ)
    );
    flopenrc #(.WIDTH(2)) regCV (
        .clk, .reset, .en(flagEn & bundleE.flagWrite[0]), .clear(1'b0),
        .d(ALUFlags[1:0]), .q(flagsCV)
    );

    always_comb begin
        mIn        = '0;
        memWriteIn = 1'b0;
        if (!StallE) begin
            mIn.valid    = CondExE;
            mIn.pcSrc    = bundleE.pcSrc & CondExE;
            mIn.regWrite = bundleE.regWrite & CondExE & ~bundleE.noWrite;
            mIn.memtoReg = bundleE.memtoReg & CondExE;
            memWriteIn   = bundleE.memWrite & CondExE;
        end
    end

    for (genvar i = 0; i < MEM_LAT; i++) begin : gMem
        if (i == 0) begin : gFirst
            flopr #(.WIDTH(M_BUNDLE_W)) regM (.clk, .reset, .d(mIn), .q(mQ[i]));
        end else begin : gRest
            flopr #(.WIDTH(M_BUNDLE_W)) regM (.clk, .reset, .d(mQ[i-1]), .q(mQ[i]));
        end
    end

    flopr #(.WIDTH(1)) regMemWrite (.clk, .reset, .d(memWriteIn), .q(MemWriteM));
    flopr #(.WIDTH(M_BUNDLE_W)) regW (.clk, .reset, .d(mQ[MEM_LAT-1]), .q(wStage));

    assign PCSrcM    = mQ[0].pcSrc;
    assign RegWriteM = mQ[0].regWrite;
    assign PCSrcW    = wStage.pcSrc;
    assign RegWriteW = wStage.regWrite;
    assign MemtoRegW = wStage.memtoReg;

    always_comb begin
        BusyMW = wStage.valid;
        for (int i = 0; i < MEM_LAT; i++) begin
            BusyMW = BusyMW | mQ[i].valid;
        end
    end

`ifdef CTRL_PIPE_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            RetiredCnt  <= '0;
            CondFailCnt <= '0;
        end else begin
            if (wStage.valid)
                RetiredCnt <= RetiredCnt + CNT_W'(1);
            if (bundleE.valid & ~CondExE & ~StallE)
                CondFailCnt <= CondFailCnt + CNT_W'(1);
        end
    end
`endif

endmodule
